writeback: RTL

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/writeback.sv
// rtl/writeback.sv - register-file writeback with in-order load tracking queue
// Optional feature macro: WB_FORWARD_EN (bypass of the registered write to rs1/rs2).
module writeback #(
    parameter int LOAD_Q_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    input  logic [2:0]  ld_issue_funct3,
    output logic        ld_issue_ready,
    input  logic        ld_resp_valid,
    input  logic [31:0] ld_resp_data,
    output logic        ld_resp_ready,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        hazard,
    output logic        dest_en,
    output logic [4:0]  dest_addr,
    output logic [31:0] dest_data,
    output logic        fwd1_en,
    output logic [31:0] fwd1_data,
    output logic        fwd2_en,
    output logic [31:0] fwd2_data
);

    localparam int PW = (LOAD_Q_DEPTH > 1) ? $clog2(LOAD_Q_DEPTH) : 1;
    localparam int CW = $clog2(LOAD_Q_DEPTH + 1);

    // Queue storage: payload is not reset, only the valid bits and pointers.
    logic [4:0]              rd_q [LOAD_Q_DEPTH];
    logic [2:0]              f3_q [LOAD_Q_DEPTH];
    logic [LOAD_Q_DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic        dest_en_q, dest_en_d;
    logic [4:0]  dest_addr_q, dest_addr_d;
    logic [31:0] dest_data_q, dest_data_d;

    logic        push, pop;
    logic [4:0]  head_rd;
    logic [2:0]  head_f3;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (LOAD_Q_DEPTH == 1) return '0;
        return (p == PW'(LOAD_Q_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'd0, d[7:0]};
            3'b101:  return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign head_rd = rd_q[head_q];
    assign head_f3 = f3_q[head_q];

    // Handshakes: reset forces both sides not-ready; ALU results always win the write port.
    always_comb begin
        ld_issue_ready = !rst && (cnt_q < CW'(LOAD_Q_DEPTH));
        ld_resp_ready  = !rst && (cnt_q != '0) && !alu_valid;
        push           = ld_issue && ld_issue_ready;
        pop            = ld_resp_valid && ld_resp_ready;
    end

    // Hazard looks only at registered entries, so a same-cycle pop still counts and a push does not.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LOAD_Q_DEPTH; i++) begin
            if (vld_q[i] && (((rs1_addr != 5'd0) && (rs1_addr == rd_q[i])) ||
                             ((rs2_addr != 5'd0) && (rs2_addr == rd_q[i])))) begin
                hazard = 1'b1;
            end
        end
        if (rst) hazard = 1'b0;
    end

    // Queue bookkeeping next-state.
    always_comb begin
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (push) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = ptr_inc(head_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Queue control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Queue payload write on accepted issue.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q] <= ld_issue_rd;
            f3_q[tail_q] <= ld_issue_funct3;
        end
    end

    // Select the write-port source; rd=0 writes are dropped and address/data hold.
    always_comb begin
        dest_en_d   = 1'b0;
        dest_addr_d = dest_addr_q;
        dest_data_d = dest_data_q;
        if (alu_valid) begin
            if (alu_rd != 5'd0) begin
                dest_en_d   = 1'b1;
                dest_addr_d = alu_rd;
                dest_data_d = alu_data;
            end
        end else if (pop) begin
            if (head_rd != 5'd0) begin
                dest_en_d   = 1'b1;
                dest_addr_d = head_rd;
                dest_data_d = ext_load(head_f3, ld_resp_data);
            end
        end
    end

    // Registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            dest_en_q   <= 1'b0;
            dest_addr_q <= 5'd0;
            dest_data_q <= 32'd0;
        end else begin
            dest_en_q   <= dest_en_d;
            dest_addr_q <= dest_addr_d;
            dest_data_q <= dest_data_d;
        end
    end

    assign dest_en   = dest_en_q && !rst;
    assign dest_addr = dest_addr_q;
    assign dest_data = dest_data_q;

`ifdef WB_FORWARD_EN
    assign fwd1_en   = dest_en && (rs1_addr != 5'd0) && (rs1_addr == dest_addr_q);
    assign fwd2_en   = dest_en && (rs2_addr != 5'd0) && (rs2_addr == dest_addr_q);
    assign fwd1_data = dest_data_q;
    assign fwd2_data = dest_data_q;
`else
    assign fwd1_en   = 1'b0;
    assign fwd2_en   = 1'b0;
    assign fwd1_data = 32'd0;
    assign fwd2_data = 32'd0;
`endif

endmodule
